// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU request buffer slice: default geometry,
// address-width helpers and the byte type used for all storage.
//   DEF_BUFFER_DEPTH : columns per bank (power of 2, at least 8)
//   DEF_COL_WIDTH    : input column height in bytes
//   baddr_bits()     : column address width
//   caddr_bits()     : input-side row address width
//   waddr_bits()     : output-side row address width
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam int DEF_BUFFER_DEPTH = 512;
    localparam int DEF_COL_WIDTH    = 10;

    typedef logic [7:0] byte_t;

    function automatic int baddr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int caddr_bits(input int col_width);
        return $clog2(col_width);
    endfunction

    // Output columns lose the two halo rows of the input column.
    function automatic int waddr_bits(input int col_width);
        return $clog2(col_width - 2);
    endfunction

endpackage

// File: rtl/fpu_buffer_bank.sv
// ----------------------------------------------------------------------------
// fpu_buffer_bank
// One ROWS x DEPTH byte array with two write ports and one registered
// full-column read port.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   col_we     : write all ROWS bytes of col_data into column col_addr
//   col_addr   : column for the full-column write
//   col_data   : byte r of the column at bits [8r+7:8r]
//   seg_we     : write 8 consecutive bytes of one row
//   seg_row    : row of the segment write (rows >= ROWS are dropped)
//   seg_idx    : 8-byte segment index within the row (column / 8)
//   seg_data   : [63:56] -> first column of the segment, [7:0] -> last
//   rd_addr    : column presented on rd_data one cycle later
//   rd_data    : registered column, byte r at bits [8r+7:8r]
// Storage is never reset; only the read register is.
// ----------------------------------------------------------------------------
module fpu_buffer_bank
    import fpu_pkg::*;
#(
    parameter int  ROWS  = DEF_COL_WIDTH,
    parameter int  DEPTH = DEF_BUFFER_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int RW    = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              col_we,
    input  logic [AW-1:0]     col_addr,
    input  logic [ROWS*8-1:0] col_data,
    input  logic              seg_we,
    input  logic [RW-1:0]     seg_row,
    input  logic [AW-4:0]     seg_idx,
    input  logic [63:0]       seg_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [ROWS*8-1:0] rd_data
);

    byte_t mem [ROWS][DEPTH];

    logic seg_row_ok;
    assign seg_row_ok = (32'(seg_row) < ROWS);

    // The array is deliberately left out of reset. The reset event only
    // blocks writes while rst_n is low, so contents survive a reset pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (col_we) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem[r][col_addr] <= col_data[8*r +: 8];
                end
            end
            if (seg_we && seg_row_ok) begin
                for (int k = 0; k < 8; k++) begin
                    mem[seg_row][{seg_idx, 3'(k)}] <= seg_data[63-8*k -: 8];
                end
            end
        end
    end

    // Stage p1: registered column read (old data on a same-edge write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                rd_data[8*r +: 8] <= mem[r][rd_addr];
            end
        end
    end

endmodule

// File: rtl/fpu_request_buffer.sv
// ----------------------------------------------------------------------------
// fpu_request_buffer
// Ping-pong byte storage between the FPU datapath and the request controller.
// Input side : controller fills bank ~rd_buffer_sel 8 bytes at a time, the
//              FPU reads a whole column from bank rd_buffer_sel.
// Output side: FPU writes a whole result column into bank wr_buffer_sel, the
//              controller drains bank ~wr_buffer_sel one byte at a time.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rd_buffer_sel         : input-side bank owned by the FPU
//   wr_buffer_sel         : output-side bank owned by the FPU
//   wr_en_rd_buffer       : controller fill strobe
//   request_write_address : {row, col} of the fill, col[2:0] ignored
//   request_data_in       : 8 fill bytes, [63:56] lands at col
//   read_col_address      : FPU input column select
//   read_col              : registered input column, row r at [8r+7:8r]
//   wr_en_wr_buffer       : FPU result write strobe
//   write_col_address     : FPU output column select
//   write_col             : result column, row r at [8r+7:8r]
//   request_read_address  : {row, col} of the drained byte
//   request_data_out      : registered drained byte
// Build option: define FPU_REQBUF_ASSERT_EN to enable simulation assertions
// on unaligned fills and out-of-range rows.
// ----------------------------------------------------------------------------
module fpu_request_buffer
    import fpu_pkg::*;
#(
    parameter int  BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter int  COL_WIDTH    = DEF_COL_WIDTH,
    localparam int BADDR_BITS   = baddr_bits(BUFFER_DEPTH),
    localparam int CADDR_BITS   = caddr_bits(COL_WIDTH),
    localparam int WADDR_BITS   = waddr_bits(COL_WIDTH),
    localparam int OUT_ROWS     = COL_WIDTH - 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rd_buffer_sel,
    input  logic                            wr_buffer_sel,
    input  logic                            wr_en_rd_buffer,
    input  logic [BADDR_BITS+CADDR_BITS-1:0] request_write_address,
    input  logic [63:0]                     request_data_in,
    input  logic [BADDR_BITS-1:0]           read_col_address,
    output logic [COL_WIDTH*8-1:0]          read_col,
    input  logic                            wr_en_wr_buffer,
    input  logic [BADDR_BITS-1:0]           write_col_address,
    input  logic [OUT_ROWS*8-1:0]           write_col,
    input  logic [BADDR_BITS+WADDR_BITS-1:0] request_read_address,
    output logic [7:0]                      request_data_out
);

    // Address fields
    logic [CADDR_BITS-1:0]   fill_row;
    logic [BADDR_BITS-4:0]   fill_idx;
    logic [WADDR_BITS-1:0]   drain_row;
    logic [BADDR_BITS-1:0]   drain_col;
    logic                    unused_fill_lsbs;

    assign fill_row  = request_write_address[BADDR_BITS+CADDR_BITS-1 -: CADDR_BITS];
    assign fill_idx  = request_write_address[BADDR_BITS-1:3];
    assign drain_row = request_read_address[BADDR_BITS+WADDR_BITS-1 -: WADDR_BITS];
    assign drain_col = request_read_address[BADDR_BITS-1:0];

    // Fills are 8-byte aligned; the low column bits carry no information.
    assign unused_fill_lsbs = ^request_write_address[2:0];

    // Per-bank write enables: the controller always owns the bank the FPU
    // is not using, so each side never writes and reads one bank together.
    logic [1:0] fill_we;
    logic [1:0] result_we;

    assign fill_we   = !wr_en_rd_buffer ? 2'b00 : (rd_buffer_sel ? 2'b01 : 2'b10);
    assign result_we = !wr_en_wr_buffer ? 2'b00 : (wr_buffer_sel ? 2'b10 : 2'b01);

    logic [COL_WIDTH*8-1:0] in_q  [2];
    logic [OUT_ROWS*8-1:0]  out_q [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fpu_buffer_bank #(
            .ROWS  (COL_WIDTH),
            .DEPTH (BUFFER_DEPTH)
        ) u_in_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .col_we   (1'b0),
            .col_addr ('0),
            .col_data ('0),
            .seg_we   (fill_we[b]),
            .seg_row  (fill_row),
            .seg_idx  (fill_idx),
            .seg_data (request_data_in),
            .rd_addr  (read_col_address),
            .rd_data  (in_q[b])
        );

        fpu_buffer_bank #(
            .ROWS  (OUT_ROWS),
            .DEPTH (BUFFER_DEPTH)
        ) u_out_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .col_we   (result_we[b]),
            .col_addr (write_col_address),
            .col_data (write_col),
            .seg_we   (1'b0),
            .seg_row  ('0),
            .seg_idx  ('0),
            .seg_data ('0),
            .rd_addr  (drain_col),
            .rd_data  (out_q[b])
        );
    end

    // Stage p1: bank and row selects captured alongside the bank read data
    logic                  rd_sel_p1;
    logic                  drain_sel_p1;
    logic [WADDR_BITS-1:0] drain_row_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_p1    <= 1'b0;
            drain_sel_p1 <= 1'b0;
            drain_row_p1 <= '0;
        end else begin
            rd_sel_p1    <= rd_buffer_sel;
            drain_sel_p1 <= ~wr_buffer_sel;
            drain_row_p1 <= drain_row;
        end
    end

    // Both bank registers clear on reset, so the final selects yield zero
    // until the first clock after reset is released.
    logic [OUT_ROWS*8-1:0] drain_col_p1;

    assign read_col     = rd_sel_p1    ? in_q[1]  : in_q[0];
    assign drain_col_p1 = drain_sel_p1 ? out_q[1] : out_q[0];

    // Row codes past the last output row read as zero.
    always_comb begin
        request_data_out = 8'h00;
        if (32'(drain_row_p1) < OUT_ROWS) begin
            request_data_out = drain_col_p1[8*drain_row_p1 +: 8];
        end
    end

`ifdef FPU_REQBUF_ASSERT_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_en_rd_buffer) begin
                a_fill_aligned: assert (request_write_address[2:0] == 3'b000);
                a_fill_row:     assert (32'(fill_row) < COL_WIDTH);
            end
            a_drain_row: assert (32'(drain_row) < OUT_ROWS);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_request_buffer.sv
// ----------------------------------------------------------------------------
// tb_fpu_request_buffer
// Self-checking bench for fpu_request_buffer with default geometry
// (512 columns, 10-byte input columns, 8-byte result columns).
// ----------------------------------------------------------------------------
module tb_fpu_request_buffer;

    localparam int DEPTH = 512;
    localparam int CW    = 10;
    localparam int ORW   = 8;

    logic        clk;
    logic        rst_n;
    logic        rd_buffer_sel;
    logic        wr_buffer_sel;
    logic        wr_en_rd_buffer;
    logic [12:0] request_write_address;
    logic [63:0] request_data_in;
    logic [8:0]  read_col_address;
    logic [79:0] read_col;
    logic        wr_en_wr_buffer;
    logic [8:0]  write_col_address;
    logic [63:0] write_col;
    logic [11:0] request_read_address;
    logic [7:0]  request_data_out;

    fpu_request_buffer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .rd_buffer_sel         (rd_buffer_sel),
        .wr_buffer_sel         (wr_buffer_sel),
        .wr_en_rd_buffer       (wr_en_rd_buffer),
        .request_write_address (request_write_address),
        .request_data_in       (request_data_in),
        .read_col_address      (read_col_address),
        .read_col              (read_col),
        .wr_en_wr_buffer       (wr_en_wr_buffer),
        .write_col_address     (write_col_address),
        .write_col             (write_col),
        .request_read_address  (request_read_address),
        .request_data_out      (request_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference storage: [bank][row][column]
    logic [7:0] in_m  [2][CW][DEPTH];
    logic [7:0] out_m [2][ORW][DEPTH];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          fill;
        logic [12:0] waddr;
        logic [63:0] wdata;
        bit          rsel;
        logic [8:0]  rcol;
        bit          chk;
        int          row;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [14];

    task automatic compare(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] wa(input int row, input int col);
        return 13'(row * DEPTH + col);
    endfunction

    function automatic logic [79:0] model_col(input int bank, input int col);
        logic [79:0] v;
        for (int r = 0; r < CW; r++) v[8*r +: 8] = in_m[bank][r][col];
        return v;
    endfunction

    function automatic logic [7:0] model_drain(input int bank, input int addr);
        int row;
        int col;
        row = addr / DEPTH;
        col = addr % DEPTH;
        if (row >= ORW) return 8'h00;
        return out_m[bank][row][col];
    endfunction

    task automatic model_writes();
        if (wr_en_rd_buffer) begin
            int row;
            int base;
            row  = int'(request_write_address) / DEPTH;
            base = ((int'(request_write_address) % DEPTH) / 8) * 8;
            if (row < CW) begin
                for (int k = 0; k < 8; k++)
                    in_m[1 - int'(rd_buffer_sel)][row][base + k] = request_data_in[63-8*k -: 8];
            end
        end
        if (wr_en_wr_buffer) begin
            for (int r = 0; r < ORW; r++)
                out_m[int'(wr_buffer_sel)][r][int'(write_col_address)] = write_col[8*r +: 8];
        end
    endtask

    // One clock: predict the outputs from the pre-edge model, apply the
    // edge's writes to the model, then sample the DUT just after the edge.
    task automatic step(input bit check);
        logic [79:0] exp_col;
        logic [7:0]  exp_byte;
        exp_col  = '0;
        exp_byte = '0;
        if (rst_n) begin
            exp_col  = model_col(int'(rd_buffer_sel), int'(read_col_address));
            exp_byte = model_drain(1 - int'(wr_buffer_sel), int'(request_read_address));
            model_writes();
        end
        @(posedge clk);
        #1;
        if (check) begin
            compare("model read_col", read_col, exp_col);
            compare("model request_data_out", {72'h0, request_data_out}, {72'h0, exp_byte});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n                 = 1'b0;
        rd_buffer_sel         = 1'b0;
        wr_buffer_sel         = 1'b0;
        wr_en_rd_buffer       = 1'b0;
        request_write_address = '0;
        request_data_in       = '0;
        read_col_address      = '0;
        wr_en_wr_buffer       = 1'b0;
        write_col_address     = '0;
        write_col             = '0;
        request_read_address  = '0;

        // Reset held for two cycles, outputs stay zero until the next clock
        repeat (2) @(posedge clk);
        #1;
        compare("reset read_col", read_col, '0);
        compare("reset request_data_out", {72'h0, request_data_out}, '0);
        rst_n = 1'b1;
        #1;
        compare("released read_col", read_col, '0);
        compare("released request_data_out", {72'h0, request_data_out}, '0);

        // Bring all four banks to known contents
        for (int i = 0; i < 1280; i++) begin
            int b;
            b = i / 640;
            wr_en_rd_buffer       = 1'b1;
            rd_buffer_sel         = (b == 0);
            request_write_address = wa((i / 64) % CW, (i % 64) * 8);
            request_data_in       = {$urandom, $urandom};
            read_col_address      = 9'($urandom);
            request_read_address  = 12'($urandom);
            if (i < 1024) begin
                wr_en_wr_buffer   = 1'b1;
                wr_buffer_sel     = (i >= 512);
                write_col_address = 9'(i % 512);
                write_col         = {$urandom, $urandom};
            end else begin
                wr_en_wr_buffer = 1'b0;
            end
            step(1'b0);
        end
        wr_en_rd_buffer      = 1'b0;
        wr_en_wr_buffer      = 1'b0;
        request_read_address = '0;

        // Directed fill / read / isolation vectors
        tbl[0]  = '{1'b1, wa(3, 16),  64'h0102030405060708, 1'b0, 9'd0,  1'b0, 0, 8'h00};
        tbl[1]  = '{1'b0, '0,         64'h0,                1'b1, 9'd18, 1'b1, 3, 8'h03};
        tbl[2]  = '{1'b0, '0,         64'h0,                1'b1, 9'd23, 1'b1, 3, 8'h08};
        tbl[3]  = '{1'b1, wa(3, 5),   64'h1122334455667788, 1'b0, 9'd0,  1'b0, 0, 8'h00};
        tbl[4]  = '{1'b0, '0,         64'h0,                1'b1, 9'd0,  1'b1, 3, 8'h11};
        tbl[5]  = '{1'b0, '0,         64'h0,                1'b1, 9'd5,  1'b1, 3, 8'h66};
        tbl[6]  = '{1'b0, '0,         64'h0,                1'b1, 9'd7,  1'b1, 3, 8'h88};
        tbl[7]  = '{1'b1, wa(4, 40),  64'hA0A1A2A3A4A5A6A7, 1'b0, 9'd0,  1'b0, 0, 8'h00};
        tbl[8]  = '{1'b1, wa(12, 40), 64'hFFFFFFFFFFFFFFFF, 1'b0, 9'd0,  1'b0, 0, 8'h00};
        tbl[9]  = '{1'b0, '0,         64'h0,                1'b1, 9'd40, 1'b1, 4, 8'hA0};
        tbl[10] = '{1'b0, '0,         64'h0,                1'b1, 9'd47, 1'b1, 4, 8'hA7};
        tbl[11] = '{1'b1, wa(4, 40),  64'h5A5B5C5D5E5F6061, 1'b1, 9'd40, 1'b1, 4, 8'hA0};
        tbl[12] = '{1'b0, '0,         64'h0,                1'b1, 9'd40, 1'b1, 4, 8'hA0};
        tbl[13] = '{1'b0, '0,         64'h0,                1'b0, 9'd40, 1'b1, 4, 8'h5A};

        for (int i = 0; i < 14; i++) begin
            wr_en_rd_buffer       = tbl[i].fill;
            request_write_address = tbl[i].waddr;
            request_data_in       = tbl[i].wdata;
            rd_buffer_sel         = tbl[i].rsel;
            read_col_address      = tbl[i].rcol;
            step(1'b1);
            if (tbl[i].chk)
                compare($sformatf("tbl[%0d] read_col row %0d", i, tbl[i].row),
                        {72'h0, read_col[8*tbl[i].row +: 8]}, {72'h0, tbl[i].exp});
        end
        wr_en_rd_buffer = 1'b0;

        // Output side: FPU fills bank 1, then the controller drains it
        wr_buffer_sel   = 1'b1;
        wr_en_wr_buffer = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            write_col_address    = 9'(c);
            write_col            = {$urandom, $urandom};
            request_read_address = 12'($urandom);
            step(1'b1);
        end
        wr_en_wr_buffer = 1'b0;
        wr_buffer_sel   = 1'b0;
        for (int r = 0; r < ORW; r++) begin
            for (int c = 0; c < DEPTH; c++) begin
                request_read_address = 12'(r * DEPTH + c);
                step(1'b1);
            end
        end

        // All four ports busy with random bank swaps
        wr_en_rd_buffer = 1'b1;
        wr_en_wr_buffer = 1'b1;
        for (int i = 0; i < 512; i++) begin
            rd_buffer_sel         = 1'($urandom);
            wr_buffer_sel         = 1'($urandom);
            request_write_address = wa($urandom_range(0, CW - 1), $urandom_range(0, 63) * 8);
            request_data_in       = {$urandom, $urandom};
            read_col_address      = 9'($urandom);
            write_col_address     = 9'($urandom);
            write_col             = {$urandom, $urandom};
            request_read_address  = 12'($urandom);
            step(1'b1);
        end

        // Reset in the middle of traffic
        rd_buffer_sel         = 1'b0;
        wr_buffer_sel         = 1'b0;
        request_write_address = wa(2, 64);
        request_data_in       = 64'hDEADBEEFCAFEF00D;
        write_col_address     = 9'd100;
        write_col             = 64'h0123456789ABCDEF;
        read_col_address      = 9'd64;
        request_read_address  = 12'(3 * DEPTH + 100);
        #2;
        rst_n = 1'b0;
        #1;
        compare("async reset read_col", read_col, '0);
        compare("async reset request_data_out", {72'h0, request_data_out}, '0);
        step(1'b1);
        rst_n = 1'b1;
        #1;
        compare("post-reset read_col", read_col, '0);
        compare("post-reset request_data_out", {72'h0, request_data_out}, '0);

        // Storage kept, reset-cycle writes discarded
        wr_en_rd_buffer  = 1'b0;
        wr_en_wr_buffer  = 1'b0;
        rd_buffer_sel    = 1'b1;
        read_col_address = 9'd64;
        wr_buffer_sel    = 1'b1;
        step(1'b1);
        read_col_address     = 9'd71;
        request_read_address = 12'(7 * DEPTH + 100);
        step(1'b1);
        rd_buffer_sel = 1'b0;
        step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
